// File: rtl/riscv_bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_bp_pkg
//  Description : Shared types and constants for the fetch-side branch
//                predictor: 2-bit counter encodings, the allocate/reset
//                counter values, and the BTB entry record.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_bp_pkg;

    // 2-bit saturating direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // A freshly allocated entry predicts taken, but one not-taken outcome
    // is enough to flip it.
    localparam ctr_e CTR_ALLOC = CTR_WT;
    localparam ctr_e CTR_RESET = CTR_WNT;

    // Widest tag any legal table size can need (ENTRIES >= 2 -> IDX_W >= 1).
    // Narrower tags are stored zero-extended into this field.
    localparam int c_tag_max_w = 29;

    typedef struct packed {
        logic                   valid;
        logic [c_tag_max_w-1:0] tag;
        logic [31:0]            target;
        ctr_e                   ctr;
    } btb_entry_t;

endpackage : riscv_bp_pkg
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter2
//  Description : Next-state logic of a 2-bit saturating direction counter.
//                Taken steps up and sticks at ST, not-taken steps down and
//                sticks at SNT.
//  Ports       : ctr     in  current counter value
//                taken   in  resolved outcome
//                ctr_nxt out counter value after training on 'taken'
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter2
    import riscv_bp_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        unique case (ctr)
            CTR_SNT: ctr_nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_nxt = taken ? CTR_ST  : CTR_WT;
            default: ctr_nxt = ctr;
        endcase
    end

endmodule : sat_counter2
`default_nettype wire

// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : btb_predictor
//  Description : Direct-mapped branch target buffer with 2-bit saturating
//                direction counters. Answers a fetch-PC lookup in the same
//                cycle from the registered table and trains on the branch
//                resolution coming back from execute.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                fetch_pc           PC being fetched (word aligned)
//                predicted_taken    redirect fetch to predicted_target
//                predicted_target   stored target on hit&taken, else pc+4
//                btb_hit            valid entry with matching tag
//                upd_valid/pc/taken/target  resolved branch to train on
//                flush              invalidate every entry
//  Config      : `define BTB_BYPASS_EN forwards a same-cycle update whose
//                PC equals fetch_pc straight to the lookup outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module btb_predictor
    import riscv_bp_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        predicted_taken,
    output logic [31:0] predicted_target,
    output logic        btb_hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    btb_entry_t r_table [ENTRIES];

    logic [IDX_W-1:0]       w_fetch_idx;
    logic [IDX_W-1:0]       w_upd_idx;
    logic [c_tag_max_w-1:0] w_fetch_tag;
    logic [c_tag_max_w-1:0] w_upd_tag;
    btb_entry_t             w_rd_entry;
    btb_entry_t             w_upd_old;
    btb_entry_t             w_upd_new;
    btb_entry_t             w_lookup;
    logic                   w_upd_hit;
    logic                   w_upd_we;
    ctr_e                   w_ctr_nxt;
    logic                   w_unused;

    assign w_fetch_idx = fetch_pc[IDX_W+1:2];
    assign w_upd_idx   = upd_pc[IDX_W+1:2];

    // Tags are kept zero-extended so one entry type serves every table size.
    always_comb begin
        w_fetch_tag              = '0;
        w_fetch_tag[TAG_W-1:0]   = fetch_pc[31:IDX_W+2];
        w_upd_tag                = '0;
        w_upd_tag[TAG_W-1:0]     = upd_pc[31:IDX_W+2];
    end

    assign w_rd_entry = r_table[w_fetch_idx];
    assign w_upd_old  = r_table[w_upd_idx];
    assign w_upd_hit  = w_upd_old.valid && (w_upd_old.tag == w_upd_tag);

    sat_counter2 u_sat_counter2 (
        .ctr     (w_upd_old.ctr),
        .taken   (upd_taken),
        .ctr_nxt (w_ctr_nxt)
    );

    // Post-update image of the entry addressed by upd_pc. A not-taken miss
    // leaves the table alone so cold not-taken branches never evict anything.
    always_comb begin
        w_upd_new = w_upd_old;
        w_upd_we  = 1'b0;
        if (upd_valid) begin
            if (w_upd_hit) begin
                w_upd_we      = 1'b1;
                w_upd_new.ctr = w_ctr_nxt;
                if (upd_taken) begin
                    w_upd_new.target = upd_target;
                end
            end else if (upd_taken) begin
                w_upd_we  = 1'b1;
                w_upd_new = '{valid: 1'b1, tag: w_upd_tag, target: upd_target, ctr: CTR_ALLOC};
            end
        end
    end

    // Priority: reset, then flush, then a single training write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i].valid <= 1'b0;
            end
        end else if (w_upd_we) begin
            r_table[w_upd_idx] <= w_upd_new;
        end
    end

`ifdef BTB_BYPASS_EN
    // Full-PC match means the update targets exactly the entry being looked
    // up, so the post-update image can be forwarded. Flush and reset discard
    // the write, so they also kill the forwarding.
    logic w_bypass;
    assign w_bypass = upd_valid && (upd_pc == fetch_pc) && !flush && !rst;
    assign w_lookup = w_bypass ? w_upd_new : w_rd_entry;
`else
    assign w_lookup = w_rd_entry;
`endif

    assign btb_hit          = w_lookup.valid && (w_lookup.tag == w_fetch_tag);
    assign predicted_taken  = btb_hit && w_lookup.ctr[1];
    assign predicted_target = predicted_taken ? w_lookup.target : (fetch_pc + 32'd4);

    // Byte-offset bits of the fetch PC carry no information for the lookup.
    assign w_unused = ^fetch_pc[1:0];

endmodule : btb_predictor
`default_nettype wire
